// File: rtl/mem_responder.sv
// mem_responder: arbitrated fetch/data RAM responder with a fixed
// access latency, RV32 load/store sizing and error flagging.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_write,
  input  logic [2:0]  d_req_funct3,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT =
    33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state_q;
  logic        last_d_q;
  logic [3:0]  cnt_q;
  logic        own_d_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        i_vld_q;
  logic        i_err_q;
  logic [31:0] i_data_q;
  logic        d_vld_q;
  logic        d_err_q;
  logic [31:0] d_data_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          idle;
  logic          gnt_d;
  logic          gnt_i;
  logic          accept;
  logic          exec;
  logic          x_d;
  logic          x_write;
  logic [2:0]    x_f3;
  logic [31:0]   x_addr;
  logic [31:0]   x_wdata;
  logic          illegal;
  logic          misal;
  logic          oob;
  logic          err;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ld;
  logic [31:0]   rdata;
  logic [31:0]   wword;
  logic          we;

  assign idle   = (state_q == IDLE) && !reset;
  assign gnt_d  = d_req_valid &&
                  (!i_req_valid || !last_d_q);
  assign gnt_i  = i_req_valid && !gnt_d;
  assign i_req_ready = idle && gnt_i;
  assign d_req_ready = idle && gnt_d;
  assign accept = i_req_ready || d_req_ready;

  // A single-cycle access executes on the
  // acceptance edge, so it uses the live request.
  always_comb begin
    if (state_q == IDLE) begin
      x_d     = gnt_d;
      x_addr  = gnt_d ? d_req_addr : i_req_addr;
      x_write = gnt_d && d_req_write;
      x_f3    = gnt_d ? d_req_funct3 : 3'b010;
      x_wdata = d_req_wdata;
    end else begin
      x_d     = own_d_q;
      x_addr  = addr_q;
      x_write = write_q;
      x_f3    = f3_q;
      x_wdata = wdata_q;
    end
  end

  assign exec = !reset &&
    ((state_q == BUSY && cnt_q == 4'd0) ||
     (LATENCY == 1 && accept));

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    case (x_f3)
      3'b000: misal = 1'b0;
      3'b001: misal = x_addr[0];
      3'b010: misal = |x_addr[1:0];
      3'b100: illegal = x_write;
      3'b101: begin
        illegal = x_write;
        misal   = x_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign oob = {1'b0, x_addr} >= LIMIT;
  assign err = illegal | misal | oob;

  assign widx  = x_addr[AW+1:2];
  assign rword = mem_q[widx];
  assign rbyte = rword[{x_addr[1:0], 3'b000} +: 8];
  assign rhalf = x_addr[1] ? rword[31:16]
                           : rword[15:0];

  always_comb begin
    case (x_f3[1:0])
      2'b00:
        ld = {{24{rbyte[7] & ~x_f3[2]}}, rbyte};
      2'b01:
        ld = {{16{rhalf[15] & ~x_f3[2]}}, rhalf};
      default: ld = rword;
    endcase
  end

  assign rdata = (err || x_write) ? '0 : ld;

  always_comb begin
    wword = rword;
    case (x_f3[1:0])
      2'b00:
        wword[{x_addr[1:0], 3'b000} +: 8] =
          x_wdata[7:0];
      2'b01:
        wword[{x_addr[1], 4'b0000} +: 16] =
          x_wdata[15:0];
      default: wword = x_wdata;
    endcase
  end

  assign we = exec && x_write && !err;

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wword;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= 4'd0;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      f3_q     <= 3'b000;
      wdata_q  <= '0;
      i_vld_q  <= 1'b0;
      i_err_q  <= 1'b0;
      i_data_q <= '0;
      d_vld_q  <= 1'b0;
      d_err_q  <= 1'b0;
      d_data_q <= '0;
    end else begin
      i_vld_q  <= 1'b0;
      i_err_q  <= 1'b0;
      i_data_q <= '0;
      d_vld_q  <= 1'b0;
      d_err_q  <= 1'b0;
      d_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            own_d_q  <= x_d;
            addr_q   <= x_addr;
            write_q  <= x_write;
            f3_q     <= x_f3;
            wdata_q  <= x_wdata;
            last_d_q <= gnt_d;
            cnt_q    <= CNT_INIT;
            state_q  <= (LATENCY > 1) ? BUSY : RESP;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
      if (exec) begin
        if (x_d) begin
          d_vld_q  <= 1'b1;
          d_err_q  <= err;
          d_data_q <= rdata;
        end else begin
          i_vld_q  <= 1'b1;
          i_err_q  <= err;
          i_data_q <= rdata;
        end
      end
    end
  end

  assign i_resp_valid = i_vld_q;
  assign i_resp_err   = i_err_q;
  assign i_resp_data  = i_data_q;
  assign d_resp_valid = d_vld_q;
  assign d_resp_err   = d_err_q;
  assign d_resp_data  = d_data_q;

endmodule
